tft_frame_scheduler: RTL and testbench
======================================

// Module: tft_frame_scheduler
// PURPOSE
// Sequences and arbitrates the single 8080-style TFT bus engine between a host command/parameter port and a
// pixel stream. It inserts the memory-write command (0x2C) ahead of each frame and aligns frame start to the
// panel tearing-effect (TE) rising edge. A frame is atomic: host commands are not interleaved with pixels.
// It sits between the AXI-lite register block / AXI-stream pixel input and the byte-level bus engine (cs_n/wr_n/rd_n/dc).
// PARAMETERS
// PIX_WIDTH      16        pixel width; RGB565; serialized MSB byte first (must be 16)
// WRITE_MEM_CMD  8'h2C     command byte issued before every frame
// TE_TIMEOUT     1000000   cycles to wait for TE rising edge before starting the frame anyway (>=2)
// TE_ENABLE_RST  1'b1      reset value of TE gating enable
// PORTS
// clk              in   1    clock
// rst              in   1    synchronous, active-high reset
// i_te_enable      in   1    1: gate frame start on TE rising edge; 0: start immediately
// i_tearing_effect in   1    raw panel TE pin (asynchronous)
// i_cmd_valid      in   1    host request pending; fields stable until o_cmd_ready
// i_cmd_dc         in   1    0: command byte, 1: parameter/data byte
// i_cmd_rnw        in   1    1: read cycle, 0: write cycle
// i_cmd_data       in   8    write byte (ignored on read)
// o_cmd_ready      out  1    1-cycle pulse: request done (write accepted / read data returned)
// o_rd_data        out  8    read byte; valid when o_cmd_ready pulses on a read; held until next read
// i_pix_valid      in   1    pixel valid
// i_pix_data       in   16   pixel
// i_pix_sof        in   1    first pixel of frame (tuser[0])
// i_pix_last       in   1    last pixel of frame
// o_pix_ready      out  1    pixel consumed this cycle
// o_bus_valid      out  1    request to bus engine
// o_bus_dc         out  1    data/command select for request
// o_bus_rnw        out  1    read/write for request
// o_bus_data       out  8    write byte
// i_bus_ready      in   1    bus engine accepts request this cycle
// i_bus_rdata      in   8    read byte from engine
// i_bus_rdata_vld  in   1    1-cycle pulse with i_bus_rdata
// o_frame_active   out  1    high from 0x2C issue through last-pixel low-byte accept
// o_te_timeout     out  1    1-cycle pulse when TE wait expired
// o_drop_count     out  16   saturating count of pixels discarded outside a frame
// BEHAVIOUR
// - Reset: all outputs 0; o_rd_data 0; o_drop_count 0; state IDLE; TE gating enable = TE_ENABLE_RST.
// - Bus handshake: transfer occurs on o_bus_valid & i_bus_ready; o_bus_* stable while valid and not ready.
// - States: IDLE, CMD, RD_WAIT, WAIT_TE, SEND_CMD, PIX_HI, PIX_LO.
// - IDLE priority: (1) i_pix_valid & i_pix_sof -> WAIT_TE (or SEND_CMD if !i_te_enable); (2) i_cmd_valid -> CMD;
//   (3) i_pix_valid & !i_pix_sof -> drop: o_pix_ready=1 for that cycle, o_drop_count+1 (sat at 16'hFFFF).
// - CMD: drive host fields; on accept: write -> o_cmd_ready pulse next cycle, IDLE; read -> RD_WAIT.
// - RD_WAIT: on i_bus_rdata_vld latch o_rd_data, pulse o_cmd_ready, IDLE. No timeout (engine guarantees reply).
// - WAIT_TE: leave on synchronized TE rising edge, or after TE_TIMEOUT cycles (pulse o_te_timeout) -> SEND_CMD.
//   TE edge seen only while in WAIT_TE counts; edges earlier are ignored.
// - SEND_CMD: dc=0, rnw=0, data=WRITE_MEM_CMD; o_frame_active set on entry; accept -> PIX_HI.
// - PIX_HI: dc=1, data=i_pix_data[15:8]; o_bus_valid only when i_pix_valid; accept -> PIX_LO.
// - PIX_LO: dc=1, data=i_pix_data[7:0]; on accept o_pix_ready=1 (same cycle); if i_pix_last -> IDLE,
//   o_frame_active cleared, else PIX_HI. Pixel data must stay stable from PIX_HI until o_pix_ready.
// - i_pix_sof seen in PIX_HI (mid-frame restart): treat as continuation; no new 0x2C. Commands wait until frame ends.
// - Throughput: one byte per cycle when i_bus_ready held high; IDLE->first bus request latency 1 cycle.
// - TE path: 2-flop synchronizer then edge detect (3 cycles TE pin to edge). rst mid-operation aborts
//   immediately: bus request dropped in the reset cycle, no o_cmd_ready/o_pix_ready generated.
// STRUCTURE
// - Package tft_sched_pkg: state enum, TFT_CMD_RAMWR=8'h2C, DC_CMD/DC_DATA constants.
// - Sub-module tft_te_sync: synchronizer, rising-edge detect, TE_TIMEOUT counter (arm/clear, edge, timeout outputs).
// - Top: FSM, output mux, drop counter.
// TESTING
// - Host write cmd 0x11, i_bus_ready=1 -> one bus xfer dc=0 rnw=0 data=0x11; o_cmd_ready pulse next cycle.
// - Host read cmd 0x0A, engine returns 0x9C 4 cycles later -> o_rd_data=0x9C, o_cmd_ready with it, no extra xfers.
// - TE enabled, 4-pixel frame 0x1234..: waits for TE edge, then bytes 2C,12,34,.. dc=0 then dc=1; 4 o_pix_ready pulses.
// - TE stuck low, TE_TIMEOUT=50 -> o_te_timeout pulse after 50 cycles, frame proceeds identically.
// - i_cmd_valid raised mid-frame -> command issued only after last pixel low byte; 3 stray non-sof pixels -> o_drop_count=3.
// - i_bus_ready toggling randomly + rst asserted mid-PIX_LO -> fields stable while stalled; all outputs 0 after reset.

Source files
------------

// File: rtl/tft_sched_pkg.sv
// Shared types and constants for the TFT frame scheduler.
package tft_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StRdWait,
    StWaitTe,
    StSendCmd,
    StPixHi,
    StPixLo
  } sched_state_e;

  localparam logic [7:0] TFT_CMD_RAMWR = 8'h2C;
  localparam logic       DC_CMD        = 1'b0;
  localparam logic       DC_DATA       = 1'b1;

endpackage

// File: rtl/tft_te_sync.sv
// Tearing-effect input synchronizer, rising-edge detector and wait timeout counter.
module tft_te_sync #(
  parameter int unsigned TE_TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_te,
  input  logic i_arm,
  output logic o_edge,
  output logic o_timeout
);

  localparam int unsigned CNT_W = $clog2(TE_TIMEOUT + 1);

  logic [1:0]       r_sync;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;
  logic             w_expired;

  assign w_rise    = r_sync[1] & ~r_prev;
  assign w_expired = (r_cnt == CNT_W'(TE_TIMEOUT - 1));
  // An edge only counts while armed; earlier edges leave no trace.
  assign o_edge    = i_arm & w_rise;
  assign o_timeout = i_arm & ~w_rise & w_expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_te};
      r_prev <= r_sync[1];
      if (!i_arm) begin
        r_cnt <= '0;
      end else if (!w_expired) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tft_frame_scheduler.sv
// Arbitrates the 8080 bus engine between host commands and atomic pixel frames,
// prefixing each frame with the memory-write command and aligning it to TE.
module tft_frame_scheduler
  import tft_sched_pkg::*;
#(
  parameter int unsigned PIX_WIDTH     = 16,
  parameter logic [7:0]  WRITE_MEM_CMD = TFT_CMD_RAMWR,
  parameter int unsigned TE_TIMEOUT    = 1000000,
  parameter logic        TE_ENABLE_RST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_te_enable,
  input  logic                 i_tearing_effect,
  input  logic                 i_cmd_valid,
  input  logic                 i_cmd_dc,
  input  logic                 i_cmd_rnw,
  input  logic [7:0]           i_cmd_data,
  output logic                 o_cmd_ready,
  output logic [7:0]           o_rd_data,
  input  logic                 i_pix_valid,
  input  logic [PIX_WIDTH-1:0] i_pix_data,
  input  logic                 i_pix_sof,
  input  logic                 i_pix_last,
  output logic                 o_pix_ready,
  output logic                 o_bus_valid,
  output logic                 o_bus_dc,
  output logic                 o_bus_rnw,
  output logic [7:0]           o_bus_data,
  input  logic                 i_bus_ready,
  input  logic [7:0]           i_bus_rdata,
  input  logic                 i_bus_rdata_vld,
  output logic                 o_frame_active,
  output logic                 o_te_timeout,
  output logic [15:0]          o_drop_count
);

  sched_state_e r_state, w_state_d;
  logic         r_te_en;
  logic         r_cmd_ready;
  logic [7:0]   r_rd_data;
  logic         r_frame_active;
  logic [15:0]  r_drop_count;

  logic         w_bus_valid;
  logic         w_bus_dc;
  logic         w_bus_rnw;
  logic [7:0]   w_bus_data;
  logic         w_pix_ready;
  logic         w_drop;
  logic         w_arm;
  logic         w_te_edge;
  logic         w_te_timeout;

  tft_te_sync #(
    .TE_TIMEOUT(TE_TIMEOUT)
  ) u_te_sync (
    .clk      (clk),
    .rst      (rst),
    .i_te     (i_tearing_effect),
    .i_arm    (w_arm),
    .o_edge   (w_te_edge),
    .o_timeout(w_te_timeout)
  );

  always_comb begin
    w_state_d   = r_state;
    w_bus_valid = 1'b0;
    w_bus_dc    = DC_CMD;
    w_bus_rnw   = 1'b0;
    w_bus_data  = '0;
    w_pix_ready = 1'b0;
    w_drop      = 1'b0;
    w_arm       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_pix_valid && i_pix_sof) begin
          w_state_d = r_te_en ? StWaitTe : StSendCmd;
        end else if (i_cmd_valid && !r_cmd_ready) begin
          // r_cmd_ready blocks re-issuing a request the host has not yet withdrawn
          w_state_d = StCmd;
        end else if (i_pix_valid) begin
          w_pix_ready = 1'b1;
          w_drop      = 1'b1;
        end
      end
      StCmd: begin
        w_bus_valid = 1'b1;
        w_bus_dc    = i_cmd_dc;
        w_bus_rnw   = i_cmd_rnw;
        w_bus_data  = i_cmd_data;
        if (i_bus_ready) begin
          w_state_d = i_cmd_rnw ? StRdWait : StIdle;
        end
      end
      StRdWait: begin
        if (i_bus_rdata_vld) begin
          w_state_d = StIdle;
        end
      end
      StWaitTe: begin
        w_arm = 1'b1;
        if (w_te_edge || w_te_timeout) begin
          w_state_d = StSendCmd;
        end
      end
      StSendCmd: begin
        w_bus_valid = 1'b1;
        w_bus_data  = WRITE_MEM_CMD;
        if (i_bus_ready) begin
          w_state_d = StPixHi;
        end
      end
      StPixHi: begin
        w_bus_valid = i_pix_valid;
        w_bus_dc    = DC_DATA;
        w_bus_data  = i_pix_data[PIX_WIDTH-1 -: 8];
        if (i_pix_valid && i_bus_ready) begin
          w_state_d = StPixLo;
        end
      end
      StPixLo: begin
        w_bus_valid = 1'b1;
        w_bus_dc    = DC_DATA;
        w_bus_data  = i_pix_data[7:0];
        if (i_bus_ready) begin
          w_pix_ready = 1'b1;
          w_state_d   = i_pix_last ? StIdle : StPixHi;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_te_en        <= TE_ENABLE_RST;
      r_cmd_ready    <= 1'b0;
      r_rd_data      <= '0;
      r_frame_active <= 1'b0;
      r_drop_count   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_te_en     <= i_te_enable;
      r_cmd_ready <= ((r_state == StCmd) && i_bus_ready && !i_cmd_rnw) ||
                     ((r_state == StRdWait) && i_bus_rdata_vld);
      if ((r_state == StRdWait) && i_bus_rdata_vld) begin
        r_rd_data <= i_bus_rdata;
      end
      if ((w_state_d == StSendCmd) && (r_state != StSendCmd)) begin
        r_frame_active <= 1'b1;
      end else if ((r_state == StPixLo) && i_bus_ready && i_pix_last) begin
        r_frame_active <= 1'b0;
      end
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  // Combinational outputs are masked during reset so an in-flight request is dropped at once.
  assign o_bus_valid    = w_bus_valid & ~rst;
  assign o_bus_dc       = w_bus_dc & ~rst;
  assign o_bus_rnw      = w_bus_rnw & ~rst;
  assign o_bus_data     = rst ? 8'h00 : w_bus_data;
  assign o_pix_ready    = w_pix_ready & ~rst;
  assign o_te_timeout   = w_te_timeout & ~rst;
  assign o_cmd_ready    = r_cmd_ready;
  assign o_rd_data      = r_rd_data;
  assign o_frame_active = r_frame_active;
  assign o_drop_count   = r_drop_count;

endmodule

// File: tb/tb_tft_frame_scheduler.sv
// Scoreboard bench for tft_frame_scheduler: directed host, TE and pixel scenarios.
module tb_tft_frame_scheduler;

  localparam int unsigned TO = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_te_enable = 1'b1;
  logic        i_tearing_effect = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        i_cmd_dc = 1'b0;
  logic        i_cmd_rnw = 1'b0;
  logic [7:0]  i_cmd_data = 8'h00;
  logic        o_cmd_ready;
  logic [7:0]  o_rd_data;
  logic        i_pix_valid = 1'b0;
  logic [15:0] i_pix_data = 16'h0000;
  logic        i_pix_sof = 1'b0;
  logic        i_pix_last = 1'b0;
  logic        o_pix_ready;
  logic        o_bus_valid;
  logic        o_bus_dc;
  logic        o_bus_rnw;
  logic [7:0]  o_bus_data;
  logic        i_bus_ready = 1'b1;
  logic [7:0]  i_bus_rdata = 8'h00;
  logic        i_bus_rdata_vld = 1'b0;
  logic        o_frame_active;
  logic        o_te_timeout;
  logic [15:0] o_drop_count;

  always #5 clk = ~clk;

  tft_frame_scheduler #(
    .TE_TIMEOUT(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_te_enable     (i_te_enable),
    .i_tearing_effect(i_tearing_effect),
    .i_cmd_valid     (i_cmd_valid),
    .i_cmd_dc        (i_cmd_dc),
    .i_cmd_rnw       (i_cmd_rnw),
    .i_cmd_data      (i_cmd_data),
    .o_cmd_ready     (o_cmd_ready),
    .o_rd_data       (o_rd_data),
    .i_pix_valid     (i_pix_valid),
    .i_pix_data      (i_pix_data),
    .i_pix_sof       (i_pix_sof),
    .i_pix_last      (i_pix_last),
    .o_pix_ready     (o_pix_ready),
    .o_bus_valid     (o_bus_valid),
    .o_bus_dc        (o_bus_dc),
    .o_bus_rnw       (o_bus_rnw),
    .o_bus_data      (o_bus_data),
    .i_bus_ready     (i_bus_ready),
    .i_bus_rdata     (i_bus_rdata),
    .i_bus_rdata_vld (i_bus_rdata_vld),
    .o_frame_active  (o_frame_active),
    .o_te_timeout    (o_te_timeout),
    .o_drop_count    (o_drop_count)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_te_to = 0;
  logic [9:0]  exp_q[$];
  logic        hold_vld = 1'b0;
  logic [9:0]  hold_f = '0;
  logic        abort = 1'b0;
  logic        force_stall = 1'b0;
  logic        rand_rdy = 1'b0;
  logic [15:0] px[4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
  int          got;
  int          lat;
  int          acc0;
  int          to0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: pops the scoreboard on every accepted transfer, checks stall stability.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_vld = 1'b0;
      end else begin
        if (hold_vld && o_bus_valid) check("bus_stable", {o_bus_dc, o_bus_rnw, o_bus_data}, hold_f);
        if (o_bus_valid && i_bus_ready) begin
          n_acc++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL bus_unexpected: got %0h expected none", {o_bus_dc, o_bus_rnw, o_bus_data});
          end else begin
            check("bus_xfer", {o_bus_dc, o_bus_rnw, o_bus_data}, exp_q.pop_front());
          end
        end
        hold_vld = o_bus_valid && !i_bus_ready;
        hold_f   = {o_bus_dc, o_bus_rnw, o_bus_data};
        if (o_te_timeout) n_te_to++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      i_bus_ready = force_stall ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Bus engine read responder: returns 0x9C four cycles after a read is accepted.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && o_bus_valid && i_bus_ready && o_bus_rnw) begin
        repeat (4) @(posedge clk);
        #1;
        i_bus_rdata     = 8'h9C;
        i_bus_rdata_vld = 1'b1;
        @(posedge clk);
        #1;
        i_bus_rdata_vld = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_cmd(input logic dc, input logic rnw, input logic [7:0] data,
                        input logic [7:0] exp_rd, output int l);
    @(posedge clk);
    #1;
    i_cmd_dc    = dc;
    i_cmd_rnw   = rnw;
    i_cmd_data  = data;
    i_cmd_valid = 1'b1;
    exp_q.push_back({dc, rnw, data});
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!o_cmd_ready && l < 200);
    if (!o_cmd_ready) check("cmd_ready_wait", 0, 1);
    else if (rnw) check("rd_data", o_rd_data, exp_rd);
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, output int g);
    int w;
    g = 0;
    exp_q.push_back({1'b0, 1'b0, 8'h2C});
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({1'b1, 1'b0, px[k][15:8]});
      exp_q.push_back({1'b1, 1'b0, px[k][7:0]});
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < n; k++) begin
      i_pix_valid = 1'b1;
      i_pix_data  = px[k];
      i_pix_sof   = (k == 0);
      i_pix_last  = (k == n - 1);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!o_pix_ready && w < 500 && !abort);
      if (abort) break;
      if (!o_pix_ready) check("pix_ready_wait", 0, 1);
      else g++;
      @(posedge clk);
      #1;
    end
    i_pix_valid = 1'b0;
    i_pix_sof   = 1'b0;
    i_pix_last  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {o_cmd_ready, o_rd_data, o_pix_ready, o_bus_valid, o_bus_dc,
                            o_bus_rnw, o_bus_data, o_frame_active, o_te_timeout}, 0);
    check("reset_drop", o_drop_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Host write: request visible one cycle after IDLE, ready the cycle after accept.
    do_cmd(1'b0, 1'b0, 8'h11, 8'h00, lat);
    check("wr_latency", lat, 3);
    @(negedge clk);
    check("cmd_ready_pulse", o_cmd_ready, 0);

    // Register read: command 0x0A then a data read returning 0x9C.
    do_cmd(1'b0, 1'b0, 8'h0A, 8'h00, lat);
    acc0 = n_acc;
    do_cmd(1'b1, 1'b1, 8'h00, 8'h9C, lat);
    repeat (5) @(posedge clk);
    check("rd_single_xfer", n_acc - acc0, 1);

    // TE-gated frame: nothing on the bus until TE rises.
    acc0 = n_acc;
    to0  = n_te_to;
    fork
      send_frame(4, got);
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("te_gate_frame_active", o_frame_active, 0);
        check("te_gate_no_xfer", n_acc - acc0, 0);
        @(posedge clk);
        #1;
        i_tearing_effect = 1'b1;
      end
    join
    check("te_frame_pix_ready", got, 4);
    check("te_frame_no_timeout", n_te_to - to0, 0);
    check("te_frame_q_empty", exp_q.size(), 0);
    @(negedge clk);
    check("te_frame_inactive", o_frame_active, 0);
    @(posedge clk);
    #1;
    i_tearing_effect = 1'b0;
    repeat (5) @(posedge clk);

    // TE stuck low: timeout pulse on the 50th WAIT_TE cycle.
    to0 = n_te_to;
    fork
      send_frame(2, got);
      begin
        @(posedge clk);
        lat = 0;
        do begin
          @(negedge clk);
          lat++;
        end while (!o_te_timeout && lat < 200);
        check("te_timeout_latency", lat, 51);
      end
    join
    check("te_timeout_pulses", n_te_to - to0, 1);
    check("te_timeout_pix_ready", got, 2);
    check("te_timeout_q_empty", exp_q.size(), 0);

    // Command raised mid-frame waits for the frame to finish; then stray pixels are dropped.
    @(posedge clk);
    #1;
    i_te_enable = 1'b0;
    repeat (2) @(posedge clk);
    fork
      send_frame(3, got);
      begin
        repeat (3) @(posedge clk);
        do_cmd(1'b0, 1'b0, 8'h29, 8'h00, lat);
      end
    join
    check("midframe_pix_ready", got, 3);
    check("midframe_q_empty", exp_q.size(), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      i_pix_valid = 1'b1;
      i_pix_sof   = 1'b0;
      i_pix_data  = 16'hBEE0 + 16'(k);
      @(negedge clk);
      check("drop_pix_ready", o_pix_ready, 1);
    end
    @(posedge clk);
    #1;
    i_pix_valid = 1'b0;
    @(negedge clk);
    check("drop_count", o_drop_count, 3);

    // Random stalls, then reset while the low byte of pixel 1 is stalled.
    rand_rdy = 1'b1;
    fork
      send_frame(4, got);
      begin
        lat = 0;
        do begin
          @(negedge clk);
          lat++;
        end while (!(o_bus_valid && i_bus_ready && o_bus_data == 8'h56) && lat < 1000);
        force_stall = 1'b1;
        @(negedge clk);
        check("stall_pix_lo", {o_bus_valid, o_bus_dc, o_bus_data}, {1'b1, 1'b1, 8'h78});
        rst   = 1'b1;
        abort = 1'b1;
        exp_q.delete();
        #1;
        check("rst_drops_valid", o_bus_valid, 0);
        check("rst_no_pix_ready", o_pix_ready, 0);
      end
    join
    force_stall = 1'b0;
    rand_rdy    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {o_cmd_ready, o_rd_data, o_pix_ready, o_bus_valid, o_bus_dc,
                          o_bus_rnw, o_bus_data, o_frame_active, o_te_timeout}, 0);
    check("rst_drop", o_drop_count, 0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    abort = 1'b0;

    do_cmd(1'b0, 1'b0, 8'h3A, 8'h00, lat);
    check("post_rst_wr_latency", lat, 3);
    repeat (3) @(posedge clk);
    check("final_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
